// File: rtl/fetch_pc_gen.sv
// PC generation and fetch control ahead of the instruction-fetch unit.
// Tracks in-flight fetches, squashes stale responses, buffers one {pc,inst}.
module fetch_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] io_pc,
  output logic        io_pc_valid,
  input  logic        io_pc_ready,
  input  logic [31:0] io_inst,
  input  logic        io_inst_valid,
  output logic        io_inst_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(MAX_OUT);
  localparam logic [PW-1:0] PLAST = PW'(MAX_OUT - 1);

  logic [63:0]   pc_reg, pc_nxt;
  logic [63:0]   pend_pc, pend_pc_nxt;
  logic          pend, pend_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] kill, kill_nxt, kill_dec;
  logic [63:0]   fifo [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic acc, rsp, stall;
  logic redir_now, redir_hold, deliver;

  assign io_pc         = pc_reg;
  assign io_pc_valid   = reset & (cnt < CMAX);
  assign io_inst_ready = (kill != '0) | ~out_valid | out_ready;

  assign acc   = io_pc_valid & io_pc_ready;
  assign rsp   = io_inst_valid & io_inst_ready;
  assign stall = io_pc_valid & ~io_pc_ready;

  // A redirect that hits a stalled request must wait for it to go out.
  assign redir_now  = redirect_valid & ~stall;
  assign redir_hold = redirect_valid & stall;
  assign deliver    = rsp & (kill == '0) & ~redirect_valid;

  assign cnt_nxt  = cnt + CW'(acc) - CW'(rsp);
  assign kill_dec = (rsp && kill != '0) ? kill - CW'(1) : kill;

  // Next pc, kill count and pending-redirect state.
  always_comb begin
    pc_nxt      = pc_reg;
    kill_nxt    = kill_dec;
    pend_nxt    = pend;
    pend_pc_nxt = pend_pc;
    if (redir_now) begin
      pc_nxt   = redirect_pc;
      kill_nxt = cnt_nxt;
      pend_nxt = 1'b0;
    end else if (redir_hold) begin
      kill_nxt    = cnt_nxt;
      pend_nxt    = 1'b1;
      pend_pc_nxt = redirect_pc;
    end else if (acc && pend) begin
      pc_nxt   = pend_pc;
      kill_nxt = kill_dec + CW'(1);
      pend_nxt = 1'b0;
    end else if (acc) begin
      pc_nxt = pc_reg + 64'd4;
    end
  end

  // Fetch-control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg  <= RESET_PC;
      pend_pc <= '0;
      pend    <= 1'b0;
      cnt     <= '0;
      kill    <= '0;
    end else begin
      pc_reg  <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      kill    <= kill_nxt;
    end
  end

  // PC FIFO pairing each response with the address that produced it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(MAX_OUT); i++) fifo[i] <= '0;
    end else begin
      if (acc) begin
        fifo[wr_ptr] <= pc_reg;
        wr_ptr <= (wr_ptr == PLAST) ? '0 : wr_ptr + PW'(1);
      end
      if (rsp) rd_ptr <= (rd_ptr == PLAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  // One-entry decode buffer; refill may coincide with drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (deliver) begin
      out_valid <= 1'b1;
      out_pc    <= fifo[rd_ptr];
      out_inst  <= io_inst;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_no_orphan_rsp: assert property (
    @(posedge clock) disable iff (!reset) !(rsp && cnt == '0)
  ) else $error("response with no outstanding request");

  a_kill_le_cnt: assert property (
    @(posedge clock) disable iff (!reset) (kill <= cnt) && (cnt <= CMAX)
  ) else $error("kill/cnt bound broken");

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen.
// Inputs change on negedge; outputs checked 1ns later.
module tb_fetch_pc_gen;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] io_pc;
  logic        io_pc_valid;
  logic        io_pc_ready;
  logic [31:0] io_inst;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_pc_gen #(.RESET_PC(RPC), .MAX_OUT(2)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .io_pc(io_pc), .io_pc_valid(io_pc_valid),
    .io_pc_ready(io_pc_ready), .io_inst(io_inst),
    .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clock = ~clock;

  task automatic idle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    io_pc_ready    = 1'b0;
    io_inst        = '0;
    io_inst_valid  = 1'b0;
    out_ready      = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    @(negedge clock);
    #1;
    n_cmp++;
    if (io_pc_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_pc_valid got %b exp 0", io_pc_valid);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid);
    end
    n_cmp++;
    if (out_pc !== 64'd0 || out_inst !== 32'd0) begin
      n_bad++; $display("FAIL rst_out_data got %h/%h exp 0/0", out_pc, out_inst);
    end
    n_cmp++;
    if (io_pc !== RPC) begin
      n_bad++; $display("FAIL rst_io_pc got %h exp %h", io_pc, RPC);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (io_pc_valid !== 1'b1 || io_pc !== RPC) begin
      n_bad++;
      $display("FAIL rel_first_req got %b/%h exp 1/%h", io_pc_valid, io_pc, RPC);
    end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      io_pc_ready   = (k < 3);
      io_inst_valid = (k >= 1 && k <= 3);
      io_inst       = 32'h0000_0013;
      #1;
      e = RPC + 64'(4 * ((k < 3) ? k : 3));
      n_cmp++;
      if (io_pc !== e) begin
        n_bad++; $display("FAIL stream_io_pc k=%0d got %h exp %h", k, io_pc, e);
      end
      if (k >= 2) begin
        e = RPC + 64'(4 * (k - 2));
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== e || out_inst !== 32'h13) begin
          n_bad++;
          $display("FAIL stream_out k=%0d got %b/%h/%h exp 1/%h/00000013",
                   k, out_valid, out_pc, out_inst, e);
        end
      end
    end
    @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_no_response();
    int accepts = 0;
    do_reset();
    io_pc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      if (io_pc_valid) accepts++;
      if (k >= 2) begin
        n_cmp++;
        if (io_pc_valid !== 1'b0 || io_pc !== RPC + 64'd8) begin
          n_bad++;
          $display("FAIL noresp_hold k=%0d got %b/%h exp 0/%h",
                   k, io_pc_valid, io_pc, RPC + 64'd8);
        end
      end
    end
    n_cmp++;
    if (accepts != 2) begin
      n_bad++; $display("FAIL noresp_accepts got %0d exp 2", accepts);
    end
  endtask

  task automatic test_redirect_kill();
    @(negedge clock);
    io_pc_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    @(negedge clock);
    redirect_valid = 1'b0;
    io_pc_ready    = 1'b0;
    io_inst_valid  = 1'b1;
    io_inst        = 32'hdead_beef;
    #1;
    n_cmp++;
    if (io_pc_valid !== 1'b0 || io_pc !== 64'h8000_1000) begin
      n_bad++;
      $display("FAIL redir_pc got %b/%h exp 0/80001000", io_pc_valid, io_pc);
    end
    n_cmp++;
    if (io_inst_ready !== 1'b1) begin
      n_bad++; $display("FAIL redir_inst_ready got %b exp 1", io_inst_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL redir_discard k=%0d got %b exp 0", k, out_valid);
      end
    end
    io_inst_valid = 1'b0;
    io_pc_ready   = 1'b1;
    n_cmp++;
    if (io_pc_valid !== 1'b1 || io_pc !== 64'h8000_1000) begin
      n_bad++;
      $display("FAIL redir_next got %b/%h exp 1/80001000", io_pc_valid, io_pc);
    end
    @(negedge clock);
    io_pc_ready   = 1'b0;
    io_inst_valid = 1'b1;
    io_inst       = 32'h0010_0093;
    @(negedge clock);
    io_inst_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000 ||
        out_inst !== 32'h0010_0093) begin
      n_bad++;
      $display("FAIL redir_out got %b/%h/%h exp 1/80001000/00100093",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_pend_redirect();
    do_reset();
    io_pc_ready = 1'b1;
    @(negedge clock);
    io_pc_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      if (k > 0) redirect_valid = 1'b0;
      #1;
      n_cmp++;
      if (io_pc_valid !== 1'b1 || io_pc !== RPC + 64'd4) begin
        n_bad++;
        $display("FAIL pend_hold k=%0d got %b/%h exp 1/%h",
                 k, io_pc_valid, io_pc, RPC + 64'd4);
      end
    end
    @(negedge clock);
    io_pc_ready = 1'b1;
    @(negedge clock);
    io_pc_ready   = 1'b0;
    io_inst_valid = 1'b1;
    io_inst       = 32'h1111_1111;
    #1;
    n_cmp++;
    if (io_pc_valid !== 1'b0 || io_pc !== 64'h8000_2000) begin
      n_bad++;
      $display("FAIL pend_newpc got %b/%h exp 0/80002000", io_pc_valid, io_pc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL pend_discard k=%0d got %b exp 0", k, out_valid);
      end
    end
    io_inst_valid = 1'b0;
    n_cmp++;
    if (io_pc_valid !== 1'b1 || io_pc !== 64'h8000_2000) begin
      n_bad++;
      $display("FAIL pend_next got %b/%h exp 1/80002000", io_pc_valid, io_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    io_pc_ready = 1'b1;
    out_ready   = 1'b0;
    @(negedge clock);
    io_inst_valid = 1'b1;
    io_inst       = 32'haaaa_aaaa;
    @(negedge clock);
    io_pc_ready = 1'b0;
    io_inst     = 32'hbbbb_bbbb;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      n_cmp++;
      if (io_inst_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_pc !== RPC || out_inst !== 32'haaaa_aaaa) begin
        n_bad++;
        $display("FAIL bp_stall k=%0d got %b/%b/%h/%h exp 0/1/%h/aaaaaaaa",
                 k, io_inst_ready, out_valid, out_pc, out_inst, RPC);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (io_inst_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release got %b exp 1", io_inst_ready);
    end
    @(negedge clock);
    io_inst_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== RPC + 64'd4 ||
        out_inst !== 32'hbbbb_bbbb) begin
      n_bad++;
      $display("FAIL bp_refill got %b/%h/%h exp 1/%h/bbbbbbbb",
               out_valid, out_pc, out_inst, RPC + 64'd4);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_empty got %b exp 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready   = 1'b0;
    io_pc_ready = 1'b1;
    @(negedge clock);
    io_inst_valid = 1'b1;
    io_inst       = 32'h0000_0013;
    @(negedge clock);
    io_inst_valid = 1'b0;
    @(negedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || io_pc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_pre got %b/%b exp 1/0", out_valid, io_pc_valid);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || io_pc_valid !== 1'b0 || out_pc !== 64'd0) begin
      n_bad++;
      $display("FAIL arst_drop got %b/%b/%h exp 0/0/0",
               out_valid, io_pc_valid, out_pc);
    end
    idle();
    out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset       = 1'b1;
    io_pc_ready = 1'b1;
    #1;
    n_cmp++;
    if (io_pc_valid !== 1'b1 || io_pc !== RPC) begin
      n_bad++;
      $display("FAIL arst_restart got %b/%h exp 1/%h", io_pc_valid, io_pc, RPC);
    end
    @(negedge clock);
    io_pc_ready   = 1'b0;
    io_inst_valid = 1'b1;
    io_inst       = 32'h0000_0517;
    @(negedge clock);
    io_inst_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== RPC || out_inst !== 32'h0000_0517) begin
      n_bad++;
      $display("FAIL arst_clean got %b/%h/%h exp 1/%h/00000517",
               out_valid, out_pc, out_inst, RPC);
    end
    n_cmp++;
    if (io_pc_valid !== 1'b1 || io_pc !== RPC + 64'd4) begin
      n_bad++;
      $display("FAIL arst_cnt got %b/%h exp 1/%h",
               io_pc_valid, io_pc, RPC + 64'd4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_no_response();
    test_redirect_kill();
    test_pend_redirect();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
